uart_frame_assembler: RTL and testbench
=======================================

# uart_frame_assembler

Collects the byte stream produced by the UART byte receiver into one fixed-width request frame (16-bit message, 32-bit exponent, 32-bit modulus = 80 bits by default). It sits directly upstream of `exponent_modulus`. It delivers each completed frame as a single-cycle valid pulse with the frame held stable. It also recovers from partial frames with an inter-byte timeout, and holds a completed frame while the downstream block is busy.

## Interface
- `FRAME_BYTES`, default 10: bytes per frame; frame width is 8*FRAME_BYTES.
- `TIMEOUT_CYCLES`, default 100_000: idle clock cycles allowed between bytes of one frame (1 ms at 100 MHz); must be ≥ 2.
- `clk_in`  input  1  system clock (100 MHz).
- `rst_in`  input  1  asynchronous, active-low reset.
- `byte_in`  input  8  received byte; valid only when `byte_valid_in` = 1.
- `byte_valid_in`  input  1  one-cycle strobe from the UART byte receiver.
- `busy_in`  input  1  downstream (expmod) busy; a frame is not released while high.
- `frame_out`  output  8*FRAME_BYTES  last completed frame; first received byte occupies bits [7:0].
- `frame_valid_out`  output  1  one-cycle pulse: `frame_out` holds a new frame.
- `byte_count_out`  output  $clog2(FRAME_BYTES+1)  bytes collected in the current partial frame.
- `timeout_out`  output  1  one-cycle pulse: a partial frame was discarded.
- `overrun_out`  output  1  one-cycle pulse: a byte was dropped while a frame was pending.

## Operation
- States: IDLE (count 0), COLLECT (0 < count < FRAME_BYTES), PENDING (frame complete, waiting for `busy_in` low).
- IDLE/COLLECT accepting a byte: write it into byte lane `count` of the assembly buffer, then increment count and clear the timeout counter. The byte order is little-endian, so lane k holds bits [8k+7:8k].
- Accepting the last byte (count = FRAME_BYTES-1) loads `frame_out` with the full buffer, including that byte, on the same edge, and resets count to 0.
  - If `busy_in` = 0 at that edge: `frame_valid_out` = 1 for the next cycle; go to IDLE.
  - Otherwise go to PENDING.
- PENDING: on the first edge with `busy_in` = 0, assert `frame_valid_out` for one cycle and go to IDLE.
  - Any `byte_valid_in` while in PENDING is dropped and pulses `overrun_out` the next cycle.
  - A byte on the same edge that PENDING exits is also dropped.
- COLLECT timeout: the counter increments on each cycle without a byte.
  - At TIMEOUT_CYCLES-1: discard the partial frame, set count to 0, pulse `timeout_out` the next cycle, go to IDLE. `frame_out` is unchanged.
- A byte arriving on the same edge as the timeout terminal count is accepted, and the timer clears; the byte wins.
- IDLE has no timeout. The counter is cleared in IDLE and PENDING.
- `frame_out` changes only on frame completion or reset. It is stable from the completion edge until the next completion.
- Only one frame is buffered; there is no queue.

## Timing
- Reset (async assert, sync deassert by system) sets all outputs to 0: `frame_out` = 0, `frame_valid_out` = 0, `byte_count_out` = 0, `timeout_out` = 0, `overrun_out` = 0. It also clears the state (IDLE), buffer and timer.
- Reset mid-frame or in PENDING discards everything; no valid pulse follows.
- Latency: last byte strobe sampled at edge N → `frame_valid_out` high during cycle N+1 when `busy_in` = 0 at edge N.
- From PENDING: release occurs one cycle after the first edge that samples `busy_in` = 0.
- `frame_valid_out`, `timeout_out` and `overrun_out` are registered, and are never high for more than one consecutive cycle.
- `byte_count_out` is registered and reflects bytes accepted through the previous edge.
- Back-to-back bytes on consecutive cycles are accepted without loss outside PENDING.

## Test plan
- Happy path: send bytes 0x01..0x0A with `busy_in` = 0 → exactly one pulse, one cycle after byte 0x0A; `frame_out` = 0x0A090807060504030201.
- Timeout: send 3 bytes, then idle for TIMEOUT_CYCLES → `timeout_out` pulses once, count returns to 0.
  - Then send 10 fresh bytes → a correct frame with no stale bytes.
- Busy hold: complete a frame with `busy_in` = 1, hold busy for 50 cycles, then drop it → `frame_out` is stable throughout; one pulse one cycle after busy falls.
- Overrun: while PENDING, send 2 bytes → two `overrun_out` pulses, count stays 0.
  - After release, the next frame assembles from new bytes only.
- Coincidence: present a byte exactly on the timeout terminal cycle → no `timeout_out`; count increments.
- Async reset: assert `rst_in` low after 6 bytes → outputs go to 0 immediately, no pulse follows.
  - After release, 10 bytes yield one correct frame.

Source files
------------

// File: rtl/uart_frame_assembler_if.sv
// rtl/uart_frame_assembler_if.sv - byte-in / frame-out bundle of the UART frame assembler
interface uart_frame_assembler_if #(
    parameter int FRAME_BYTES = 10
) ();
    logic [7:0]                       byte_in;
    logic                             byte_valid_in;
    logic                             busy_in;
    logic [8*FRAME_BYTES-1:0]         frame_out;
    logic                             frame_valid_out;
    logic [$clog2(FRAME_BYTES+1)-1:0] byte_count_out;
    logic                             timeout_out;
    logic                             overrun_out;

    // Byte source / downstream consumer side
    modport master (
        output byte_in, byte_valid_in, busy_in,
        input  frame_out, frame_valid_out, byte_count_out, timeout_out, overrun_out
    );

    // Assembler side
    modport slave (
        input  byte_in, byte_valid_in, busy_in,
        output frame_out, frame_valid_out, byte_count_out, timeout_out, overrun_out
    );
endinterface

// File: rtl/uart_frame_assembler.sv
// rtl/uart_frame_assembler.sv - assembles UART bytes into one fixed-width request frame
module uart_frame_assembler #(
    parameter int FRAME_BYTES    = 10,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    uart_frame_assembler_if.slave bus
);
    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int FW = 8 * FRAME_BYTES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   buf_q, buf_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            frame_valid_q, frame_valid_d;
    logic            timeout_q, timeout_d;
    logic            overrun_q, overrun_d;

    // State register and all output flops; reset discards any partial or pending frame
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            count_q       <= '0;
            timer_q       <= '0;
            buf_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            buf_q         <= buf_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic: byte capture, frame completion, inter-byte timeout, pending release
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        timer_d       = timer_q;
        buf_d         = buf_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        timeout_d     = 1'b0;
        overrun_d     = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if (bus.byte_valid_in) begin
                    // Little-endian: lane k of the buffer takes the k-th byte of the frame
                    for (int k = 0; k < FRAME_BYTES; k++) begin
                        if (count_q == CW'(k)) begin
                            buf_d[8*k +: 8] = bus.byte_in;
                        end
                    end
                    timer_d = '0;
                    if (count_q == CW'(FRAME_BYTES - 1)) begin
                        // The completing byte is folded in through buf_d on this same edge
                        frame_d = buf_d;
                        count_d = '0;
                        if (bus.busy_in) begin
                            state_d = PENDING;
                        end else begin
                            frame_valid_d = 1'b1;
                            state_d       = IDLE;
                        end
                    end else begin
                        count_d = count_q + CW'(1);
                        state_d = COLLECT;
                    end
                end else if (state_q == COLLECT) begin
                    if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timer_d   = '0;
                        count_d   = '0;
                        buf_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else begin
                    timer_d = '0;
                end
            end
            PENDING: begin
                // Single-frame buffer: any byte here is lost, including on the release edge
                timer_d = '0;
                if (bus.byte_valid_in) begin
                    overrun_d = 1'b1;
                end
                if (!bus.busy_in) begin
                    frame_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                timer_d = '0;
            end
        endcase
    end

    assign bus.frame_out       = frame_q;
    assign bus.frame_valid_out = frame_valid_q;
    assign bus.byte_count_out  = count_q;
    assign bus.timeout_out     = timeout_q;
    assign bus.overrun_out     = overrun_q;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb/tb_uart_frame_assembler.sv - randomized self-checking bench for uart_frame_assembler
module tb_uart_frame_assembler;
    localparam int N = 10;
    localparam int T = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_assembler_if #(.FRAME_BYTES(N)) bus ();

    uart_frame_assembler #(
        .FRAME_BYTES   (N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int fv_seen, to_seen, ov_seen;

    // Reference model state: bytes of the partial frame, idle gap length, pending flag
    logic [7:0]     part_q[$];
    int             idle_gap;
    bit             pending;
    logic [8*N-1:0] exp_frame;
    bit             exp_fv, exp_to, exp_ov;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        part_q.delete();
        idle_gap  = 0;
        pending   = 1'b0;
        exp_frame = '0;
        exp_fv    = 1'b0;
        exp_to    = 1'b0;
        exp_ov    = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit bz);
        exp_fv = 1'b0;
        exp_to = 1'b0;
        exp_ov = 1'b0;
        if (pending) begin
            if (v) exp_ov = 1'b1;
            if (!bz) begin
                pending = 1'b0;
                exp_fv  = 1'b1;
            end
        end else if (v) begin
            part_q.push_back(b);
            idle_gap = 0;
            if (part_q.size() == N) begin
                exp_frame = '0;
                for (int k = 0; k < N; k++) exp_frame = exp_frame | ({{(8*N-8){1'b0}}, part_q[k]} << (8 * k));
                part_q.delete();
                if (bz) pending = 1'b1;
                else    exp_fv  = 1'b1;
            end
        end else if (part_q.size() > 0) begin
            idle_gap++;
            if (idle_gap == T) begin
                part_q.delete();
                idle_gap = 0;
                exp_to   = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("frame_out",   bus.frame_out,       exp_frame);
        check_eq("frame_valid", bus.frame_valid_out, exp_fv);
        check_eq("byte_count",  bus.byte_count_out,  part_q.size());
        check_eq("timeout",     bus.timeout_out,     exp_to);
        check_eq("overrun",     bus.overrun_out,     exp_ov);
        fv_seen += int'(bus.frame_valid_out);
        to_seen += int'(bus.timeout_out);
        ov_seen += int'(bus.overrun_out);
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit bz);
        bus.byte_valid_in = v;
        bus.byte_in       = b;
        bus.busy_in       = bz;
        @(posedge clk);
        model_step(v, b, bz);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit bz);
        repeat (n) step(1'b0, 8'h00, bz);
    endtask

    task automatic send_frame(input logic [7:0] first, input bit last_busy);
        for (int i = 0; i < N; i++) step(1'b1, first + 8'(i), (i == N - 1) ? last_busy : 1'b0);
    endtask

    task automatic clear_counts();
        fv_seen = 0;
        to_seen = 0;
        ov_seen = 0;
    endtask

    logic [8*N-1:0] hold;
    bit             rb;
    int             rate;

    initial begin
        bus.byte_valid_in = 1'b0;
        bus.byte_in       = 8'h00;
        bus.busy_in       = 1'b0;
        model_reset();
        clear_counts();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Happy path
        clear_counts();
        send_frame(8'h01, 1'b0);
        idle(3, 1'b0);
        check_eq("happy_pulses", fv_seen, 1);
        check_eq("happy_frame", bus.frame_out, 80'h0A090807060504030201);

        // Timeout after 3 bytes, then a clean frame
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        idle(T + 2, 1'b0);
        check_eq("timeout_pulses", to_seen, 1);
        check_eq("timeout_count", bus.byte_count_out, 0);
        send_frame(8'h11, 1'b0);
        idle(1, 1'b0);
        check_eq("post_timeout_frame", bus.frame_out, 80'h1A191817161514131211);

        // Busy hold
        clear_counts();
        send_frame(8'h21, 1'b1);
        hold = bus.frame_out;
        idle(50, 1'b1);
        check_eq("busy_no_pulse", fv_seen, 0);
        check_eq("busy_stable", bus.frame_out, hold);
        step(1'b0, 8'h00, 1'b0);
        check_eq("busy_release", bus.frame_valid_out, 1'b1);
        idle(2, 1'b0);
        check_eq("busy_pulses", fv_seen, 1);
        check_eq("busy_frame", hold, 80'h2A292827262524232221);

        // Overrun while pending
        clear_counts();
        send_frame(8'h31, 1'b1);
        step(1'b1, 8'hEE, 1'b1);
        step(1'b1, 8'hEF, 1'b1);
        check_eq("overrun_pulses", ov_seen, 2);
        check_eq("overrun_count", bus.byte_count_out, 0);
        step(1'b0, 8'h00, 1'b0);
        send_frame(8'h41, 1'b0);
        idle(1, 1'b0);
        check_eq("post_overrun_frame", bus.frame_out, 80'h4A494847464544434241);

        // Byte arriving on the timeout terminal cycle wins
        clear_counts();
        step(1'b1, 8'h5A, 1'b0);
        idle(T - 1, 1'b0);
        step(1'b1, 8'h5B, 1'b0);
        check_eq("coincide_no_timeout", to_seen, 0);
        check_eq("coincide_count", bus.byte_count_out, 2);
        idle(T + 2, 1'b0);

        // Asynchronous reset mid-frame
        clear_counts();
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
        bus.byte_valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_frame", bus.frame_out, 0);
        check_eq("rst_count", bus.byte_count_out, 0);
        check_eq("rst_pulses", {bus.frame_valid_out, bus.timeout_out, bus.overrun_out}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5, 1'b0);
        check_eq("rst_no_pulse", fv_seen, 0);
        send_frame(8'h51, 1'b0);
        idle(1, 1'b0);
        check_eq("post_reset_frame", bus.frame_out, 80'h5A595857565554535251);

        // Randomized traffic with varying byte density and busy behaviour
        rb = 1'b0;
        for (int blk = 0; blk < 20; blk++) begin
            case (blk % 4)
                0:       rate = 2;
                1:       rate = 3;
                2:       rate = 12;
                default: rate = 40;
            endcase
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(7) == 0) rb = ~rb;
                step(($urandom_range(rate - 1) == 0), 8'($urandom), rb);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
